gate_tt_sweeper: RTL and testbench

- Sequential characterization stage that sits directly upstream of a synthesized combinational gate netlist (4-input NOT/NOR genetic-logic design, truth table 0x0304).
- Steps the netlist's inputs through all 2^N_IN combinations and waits a programmable settle time for each one.
- Samples the netlist output through a synchronizer and assembles the observed truth table.
- Compares the observed table against the expected table and reports pass/fail plus a mismatch count.

---
 rtl/gate_tt_sweeper.sv | 151 +++++++++++++++
 tb/tb_gate_tt_sweeper.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/gate_tt_sweeper.sv
// rtl/gate_tt_sweeper.sv - sweeps a combinational netlist through all input combinations and checks its truth table
// Optional instability detection: define GATE_TT_UNSTABLE_DETECT_EN.
module gate_tt_sweeper #(
    parameter int                     N_IN          = 4,
    parameter int                     SETTLE_CYCLES = 8,
    parameter logic [(1<<N_IN)-1:0]   EXPECTED      = 16'h0304
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    output logic [N_IN-1:0]        drv_in,
    input  logic                   dut_out,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [(1<<N_IN)-1:0]   tt_obs,
    output logic [N_IN:0]          mismatch_cnt,
    output logic [(1<<N_IN)-1:0]   unstable_mask
);
    localparam int TT_W = 1 << N_IN;

    typedef enum logic [2:0] {S_IDLE, S_DRIVE, S_SETTLE, S_SAMPLE, S_DONE} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [N_IN-1:0]   r_idx;
    logic [7:0]        r_cnt;
    logic              r_sync1;
    logic              r_sync2;
    logic [N_IN-1:0]   r_drv;
    logic              r_pass;
    logic [TT_W-1:0]   r_tt;
    logic [N_IN:0]     r_mm;
    logic [TT_W-1:0]   r_unst;
    logic [TT_W-1:0]   w_tt_nxt;
    logic [TT_W-1:0]   w_unst_nxt;
    logic [N_IN:0]     w_mm;
    logic              w_pass;
    logic              w_last;
    logic              w_abort;

    assign w_last  = (r_idx == {N_IN{1'b1}});
    assign w_abort = abort && (r_state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (start && !abort) w_state_nxt = S_DRIVE;
            S_DRIVE:  w_state_nxt = S_SETTLE;
            S_SETTLE: if (r_cnt == 8'(SETTLE_CYCLES - 1)) w_state_nxt = S_SAMPLE;
            S_SAMPLE: w_state_nxt = w_last ? S_DONE : S_DRIVE;
            S_DONE:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
        if (w_abort) w_state_nxt = S_IDLE;
    end

    // Final verdict is computed from the table including the bit being sampled now,
    // so pass/mismatch_cnt are already valid in the DONE cycle.
    always_comb begin
        w_tt_nxt = r_tt;
        if (r_state == S_SAMPLE) w_tt_nxt[r_idx] = r_sync2;
    end

`ifdef GATE_TT_UNSTABLE_DETECT_EN
    logic r_out_prev;
    logic w_window;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_out_prev <= 1'b0;
        else        r_out_prev <= r_sync2;
    end

    assign w_window = ((r_state == S_SETTLE) && (r_cnt >= 8'(SETTLE_CYCLES - 2)))
                   || (r_state == S_SAMPLE);

    always_comb begin
        w_unst_nxt = r_unst;
        if (w_window && (r_sync2 != r_out_prev)) w_unst_nxt[r_idx] = 1'b1;
    end
`else
    assign w_unst_nxt = '0;
`endif

    assign w_mm   = (N_IN + 1)'($countones(w_tt_nxt ^ EXPECTED));
    assign w_pass = (w_tt_nxt == EXPECTED) && (w_unst_nxt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx   <= '0;
            r_cnt   <= '0;
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_drv   <= '0;
            r_pass  <= 1'b0;
            r_tt    <= '0;
            r_mm    <= '0;
            r_unst  <= '0;
        end else begin
            r_sync1 <= dut_out;
            r_sync2 <= r_sync1;
            if (w_abort) begin
                r_drv  <= '0;
                r_pass <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: if (start) begin
                        r_idx  <= '0;
                        r_drv  <= '0;
                        r_tt   <= '0;
                        r_pass <= 1'b0;
                        r_mm   <= '0;
                        r_unst <= '0;
                    end
                    S_DRIVE:  r_cnt <= '0;
                    S_SETTLE: begin
                        r_cnt  <= r_cnt + 8'd1;
                        r_unst <= w_unst_nxt;
                    end
                    S_SAMPLE: begin
                        r_tt   <= w_tt_nxt;
                        r_unst <= w_unst_nxt;
                        if (w_last) begin
                            r_drv  <= '0;
                            r_pass <= w_pass;
                            r_mm   <= w_mm;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                            r_drv <= r_idx + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign drv_in        = r_drv;
    assign busy          = (r_state != S_IDLE);
    assign done          = (r_state == S_DONE);
    assign pass          = r_pass;
    assign tt_obs        = r_tt;
    assign mismatch_cnt  = r_mm;
    assign unstable_mask = r_unst;
endmodule

// File: tb/tb_gate_tt_sweeper.sv
// tb/tb_gate_tt_sweeper.sv - table-driven self-checking bench for gate_tt_sweeper
module tb_gate_tt_sweeper;
`ifdef GATE_TT_UNSTABLE_DETECT_EN
    localparam bit UD = 1'b1;
`else
    localparam bit UD = 1'b0;
`endif
    localparam int NO_EVT = -10;

    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0, dut_out = 1'b0;
    logic [3:0]  drv_in;
    logic        busy, done, pass;
    logic [15:0] tt_obs, unstable_mask;
    logic [4:0]  mismatch_cnt;

    logic [15:0] m_exp = 16'h0304;
    logic [15:0] m_flip = 16'h0000;
    logic        m_glitch = 1'b0;
    logic        m_val;

    int n_chk = 0, n_pass = 0;

    always #5 clk = ~clk;

    gate_tt_sweeper #(.N_IN(4), .SETTLE_CYCLES(8), .EXPECTED(16'h0304)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .drv_in(drv_in),
        .dut_out(dut_out), .busy(busy), .done(done), .pass(pass), .tt_obs(tt_obs),
        .mismatch_cnt(mismatch_cnt), .unstable_mask(unstable_mask)
    );

    always_comb m_val = m_exp[drv_in] ^ m_flip[drv_in] ^ m_glitch;
    always @(m_val) dut_out <= #5 m_val;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, " busy"}, 32'(busy), 0);
        chk({tag, " done"}, 32'(done), 0);
        chk({tag, " pass"}, 32'(pass), 0);
        chk({tag, " drv_in"}, 32'(drv_in), 0);
        chk({tag, " tt_obs"}, 32'(tt_obs), 0);
        chk({tag, " mismatch_cnt"}, 32'(mismatch_cnt), 0);
        chk({tag, " unstable_mask"}, 32'(unstable_mask), 0);
    endtask

    // Called at a negedge; cycle n=1 is the first cycle after the edge that samples start.
    task automatic run(input int abort_at, input int restart_at, input int glitch_at,
                       input int rst_at, input int limit, output int done_cyc, output int drv_err);
        int n;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        done_cyc = 0;
        drv_err = 0;
        while (n <= limit) begin
            if (done && done_cyc == 0) done_cyc = n;
            if (abort_at < 0 && rst_at < 0) begin
                if (n <= 160 && drv_in != 4'((n - 1) / 10)) drv_err++;
                if (n == 161 && drv_in != 4'd0) drv_err++;
            end
            if (n == abort_at + 1) begin
                chk("abort busy", 32'(busy), 0);
                chk("abort drv_in", 32'(drv_in), 0);
            end
            abort = (n == abort_at);
            start = (n == restart_at);
            if (n == glitch_at)     begin #1 m_glitch = 1'b1; end
            if (n == glitch_at + 1) begin #1 m_glitch = 1'b0; end
            if (n == rst_at) begin
                #1 rst_n = 1'b0;
                #1 chk_zero_outputs("async reset");
                break;
            end
            if (done_cyc != 0) break;
            @(negedge clk);
            n++;
        end
        abort = 1'b0;
        start = 1'b0;
    endtask

    typedef struct {
        logic [15:0] flip;
        int          restart_at;
        int          glitch_at;
        logic [15:0] exp_tt;
        logic        exp_pass;
        logic [4:0]  exp_mm;
        logic [15:0] exp_unst;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int dc, de;
        vecs[0] = '{16'h0000, -1, NO_EVT, 16'h0304, 1'b1, 5'd0, 16'h0000};
        vecs[1] = '{16'h0104, -1, NO_EVT, 16'h0200, 1'b0, 5'd2, 16'h0000};
        vecs[2] = '{16'h0000, 80, NO_EVT, 16'h0304, 1'b1, 5'd0, 16'h0000};
        vecs[3] = '{16'h0000, -1, 55, 16'h0304, !UD, 5'd0, UD ? 16'h0020 : 16'h0000};
        vecs[4] = '{16'hFFFF, -1, NO_EVT, 16'hFCFB, 1'b0, 5'd16, 16'h0000};

        repeat (3) @(negedge clk);
        chk_zero_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle busy", 32'(busy), 0);

        for (int i = 0; i < 5; i++) begin
            m_flip = vecs[i].flip;
            run(-1, vecs[i].restart_at, vecs[i].glitch_at, -1, 300, dc, de);
            chk($sformatf("v%0d done cycle", i), 32'(dc), 161);
            chk($sformatf("v%0d drv_in sequence errors", i), 32'(de), 0);
            chk($sformatf("v%0d tt_obs", i), 32'(tt_obs), 32'(vecs[i].exp_tt));
            chk($sformatf("v%0d pass", i), 32'(pass), 32'(vecs[i].exp_pass));
            chk($sformatf("v%0d mismatch_cnt", i), 32'(mismatch_cnt), 32'(vecs[i].exp_mm));
            chk($sformatf("v%0d unstable_mask", i), 32'(unstable_mask), 32'(vecs[i].exp_unst));
            @(negedge clk);
            chk($sformatf("v%0d busy after done", i), 32'(busy), 0);
            chk($sformatf("v%0d pass held", i), 32'(pass), 32'(vecs[i].exp_pass));
        end

        m_flip = 16'h0000;
        run(50, -1, NO_EVT, -1, 200, dc, de);
        chk("abort no done", 32'(dc), 0);
        chk("abort pass", 32'(pass), 0);
        chk("abort partial tt_obs", 32'(tt_obs), 32'h0004);
        run(-1, -1, NO_EVT, -1, 300, dc, de);
        chk("after abort done cycle", 32'(dc), 161);
        chk("after abort pass", 32'(pass), 1);

        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        chk("start+abort busy", 32'(busy), 0);
        repeat (3) @(negedge clk);
        chk("start+abort still idle", 32'(busy), 0);
        chk("start+abort done", 32'(done), 0);

        run(-1, -1, NO_EVT, 100, 300, dc, de);
        chk("reset no done", 32'(dc), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("post-reset idle busy", 32'(busy), 0);
        chk("post-reset drv_in", 32'(drv_in), 0);
        run(-1, -1, NO_EVT, -1, 300, dc, de);
        chk("post-reset done cycle", 32'(dc), 161);
        chk("post-reset tt_obs", 32'(tt_obs), 32'h0304);
        chk("post-reset pass", 32'(pass), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
